// File: rtl/note_display_ctrl.sv
// note_display_ctrl: buffers note events, places them on a fixed grid and sequences
// draws and full-screen wipes for vga_data.
module note_display_ctrl #(
  parameter int DRAW_CYCLES  = 432,
  parameter int CLEAR_CYCLES = 19200,
  parameter int FIFO_DEPTH   = 4,
  parameter int COLS         = 4,
  parameter int ROWS         = 8,
  parameter int X0           = 8,
  parameter int Y0           = 2,
  parameter int CELL_W       = 36,
  parameter int CELL_H       = 14
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       note_valid,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  input  logic       clear_req,
  output logic [3:0] note,
  output logic [1:0] octave,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       ld_note,
  output logic       clear,
  output logic       busy,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CNT_MAX = CLEAR_CYCLES > DRAW_CYCLES ? CLEAR_CYCLES : DRAW_CYCLES;
  localparam int NW = $clog2(CNT_MAX + 1);
  localparam logic [NW-1:0] CLR_LAST = NW'(CLEAR_CYCLES - 1);
  localparam logic [NW-1:0] DRW_LAST = NW'(DRAW_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOAD, S_DRAW, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic [5:0]      mem_q [FIFO_DEPTH];
  logic [3:0]      note_q, note_d;
  logic [1:0]      octave_q, octave_d;
  logic [7:0]      x_q, x_d, px, py;
  logic [6:0]      y_q, y_d;
  logic            ld_note_q, clear_q, busy_q, overflow_q, overflow_d;
  logic            empty, full, evt, pop, push;
  logic [5:0]      head;

  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign evt   = note_valid && !clear_req && note_in != 4'd0 && note_in <= 4'd12;
  assign pop   = state_q == S_LOAD;
  // a same-cycle pop frees the slot, so a full FIFO can still accept
  assign push  = evt && (!full || pop);
  assign head  = mem_q[rd_q[AW-1:0]];
  assign px    = 8'(X0) + 8'(col_q) * 8'(CELL_W);
  assign py    = 8'(Y0) + 8'(row_q) * 8'(CELL_H);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      S_CLEAR: begin
        cnt_d   = cnt_q == CLR_LAST ? '0 : cnt_q + NW'(1);
        state_d = cnt_q == CLR_LAST ? S_IDLE : S_CLEAR;
      end
      S_IDLE: state_d = empty ? S_IDLE : S_LOAD;
      S_LOAD: state_d = S_DRAW;
      S_DRAW: begin
        cnt_d = cnt_q + NW'(1);
        if (cnt_q == DRW_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          col_d   = col_q == COL_LAST ? '0 : col_q + CW'(1);
          row_d   = col_q != COL_LAST ? row_q : row_q == ROW_LAST ? '0 : row_q + RW'(1);
        end
      end
      S_GAP:   state_d = (col_q == '0 && row_q == '0) ? S_CLEAR : S_IDLE;
      default: state_d = S_CLEAR;
    endcase
    if (clear_req) begin
      state_d = S_CLEAR;
      cnt_d   = '0;
      col_d   = '0;
      row_d   = '0;
    end
  end

  always_comb begin
    wr_d       = clear_req ? '0 : wr_q + (AW+1)'(push);
    rd_d       = clear_req ? '0 : rd_q + (AW+1)'(pop);
    overflow_d = !clear_req && (overflow_q || (evt && full && !pop));
    note_d     = pop ? head[3:0] : note_q;
    octave_d   = pop ? head[5:4] : octave_q;
    x_d        = pop ? px : x_q;
    y_d        = pop ? py[6:0] : y_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {octave_in, note_in};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      note_q     <= '0;
      octave_q   <= '0;
      x_q        <= 8'(X0);
      y_q        <= 7'(Y0);
      ld_note_q  <= 1'b0;
      clear_q    <= 1'b0;
      busy_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      note_q     <= note_d;
      octave_q   <= octave_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ld_note_q  <= state_d == S_DRAW;
      clear_q    <= state_d != S_CLEAR;
      busy_q     <= state_d != S_IDLE;
      overflow_q <= overflow_d;
    end
  end

  assign note     = note_q;
  assign octave   = octave_q;
  assign x        = x_q;
  assign y        = y_q;
  assign ld_note  = ld_note_q;
  assign clear    = clear_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_note_display_ctrl.sv
// tb_note_display_ctrl: directed bench for note_display_ctrl with default parameters;
// a negedge monitor logs every ld_note burst and every clear-low run.
module tb_note_display_ctrl;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       note_valid = 1'b0;
  logic [3:0] note_in = '0;
  logic [1:0] octave_in = '0;
  logic       clear_req = 1'b0;
  logic [3:0] note;
  logic [1:0] octave;
  logic [7:0] x;
  logic [6:0] y;
  logic       ld_note, clear, busy, overflow;

  always #5 clk = ~clk;

  note_display_ctrl dut (
    .clk(clk), .resetn(resetn), .note_valid(note_valid), .note_in(note_in),
    .octave_in(octave_in), .clear_req(clear_req), .note(note), .octave(octave),
    .x(x), .y(y), .ld_note(ld_note), .clear(clear), .busy(busy), .overflow(overflow)
  );

  typedef struct {
    int note;
    int oct;
    int x;
    int y;
    int len;
    int start;
    bit stable;
  } draw_t;

  draw_t draws[$];
  int    clear_runs[$];
  draw_t cur;
  bit    ld_prev = 1'b0;
  int    clr_run = 0;
  int    ld_in_wipe = 0;
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!resetn) begin
      ld_prev = 1'b0;
      clr_run = 0;
    end else begin
      if (ld_note && !ld_prev)
        cur = '{note: int'(note), oct: int'(octave), x: int'(x), y: int'(y), len: 1, start: cyc, stable: 1'b1};
      else if (ld_note) begin
        cur.len++;
        if (cur.note != int'(note) || cur.oct != int'(octave) || cur.x != int'(x) || cur.y != int'(y))
          cur.stable = 1'b0;
      end else if (ld_prev)
        draws.push_back(cur);
      ld_prev = ld_note;
      if (!clear) clr_run++;
      else if (clr_run != 0) begin
        clear_runs.push_back(clr_run);
        clr_run = 0;
      end
      if (ld_note && !clear) ld_in_wipe++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int n, input int o, output int acc);
    note_valid = 1'b1;
    note_in    = 4'(n);
    octave_in  = 2'(o);
    @(posedge clk);
    #1;
    note_valid = 1'b0;
    acc        = cyc;
  endtask

  task automatic wait_draws(input int n, input int budget);
    for (int i = 0; i < budget && draws.size() < n; i++) step(1);
    chk("draw_count", draws.size(), n);
  endtask

  task automatic wait_clr(input int n, input int budget);
    for (int i = 0; i < budget && clear_runs.size() < n; i++) step(1);
    chk("wipe_count", clear_runs.size(), n);
  endtask

  initial begin
    int    acc;
    draw_t d;
    step(3);
    chk("rst_note", note, 0);
    chk("rst_octave", octave, 0);
    chk("rst_x", x, 8);
    chk("rst_y", y, 2);
    chk("rst_ld", ld_note, 0);
    chk("rst_clear", clear, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ovf", overflow, 0);
    resetn = 1'b1;
    wait_clr(1, 20000);
    if (clear_runs.size() >= 1) chk("rst_wipe_len", clear_runs[0], 19200);
    chk("rst_busy_idle", busy, 0);
    chk("rst_no_draw", draws.size(), 0);

    send(0, 1, acc);
    send(13, 2, acc);
    send(15, 3, acc);
    step(10);
    chk("inv_busy", busy, 0);
    chk("inv_ovf", overflow, 0);
    chk("inv_no_draw", draws.size(), 0);

    send(5, 2, acc);
    wait_draws(1, 1000);
    if (draws.size() >= 1) begin
      d = draws[0];
      chk("one_note", d.note, 5);
      chk("one_oct", d.oct, 2);
      chk("one_x", d.x, 8);
      chk("one_y", d.y, 2);
      chk("one_len", d.len, 432);
      chk("one_stable", int'(d.stable), 1);
      chk("one_latency", d.start - acc, 2);
    end

    for (int k = 2; k <= 32; k++) begin
      send((k % 12) + 1, k % 4, acc);
      wait_draws(k, 1000);
      if (draws.size() >= k) begin
        d = draws[k-1];
        chk("grid_x", d.x, 8 + 36 * ((k - 1) % 4));
        chk("grid_y", d.y, 2 + 14 * (((k - 1) / 4) % 8));
        chk("grid_note", d.note, (k % 12) + 1);
      end
    end
    chk("wrap_clear", clear, 0);

    send(1, 0, acc);
    send(2, 1, acc);
    send(3, 2, acc);
    send(4, 3, acc);
    send(12, 3, acc);
    chk("ovf_set", overflow, 1);
    wait_clr(2, 20000);
    if (clear_runs.size() >= 2) chk("wrap_wipe_len", clear_runs[1], 19200);
    wait_draws(36, 3000);
    if (draws.size() >= 36) begin
      for (int i = 0; i < 4; i++) begin
        chk("burst_x", draws[32+i].x, 8 + 36 * i);
        chk("burst_y", draws[32+i].y, 2);
        chk("burst_note", draws[32+i].note, i + 1);
      end
      chk("burst_pitch", draws[33].start - draws[32].start, 435);
    end
    step(600);
    chk("fifth_dropped", draws.size(), 36);
    chk("burst_idle", busy, 0);

    send(6, 1, acc);
    send(7, 2, acc);
    send(8, 3, acc);
    step(100);
    chk("abort_ld_before", ld_note, 1);
    clear_req  = 1'b1;
    note_valid = 1'b1;
    note_in    = 4'd3;
    @(posedge clk);
    #1;
    clear_req  = 1'b0;
    note_valid = 1'b0;
    chk("abort_ld", ld_note, 0);
    chk("abort_clear", clear, 0);
    chk("abort_ovf", overflow, 0);
    wait_clr(3, 20000);
    if (clear_runs.size() >= 3) chk("abort_wipe_len", clear_runs[2], 19200);
    chk("abort_idle", busy, 0);
    step(20);
    chk("abort_flushed", draws.size(), 37);
    if (draws.size() >= 37) begin
      chk("abort_len", draws[36].len, 101);
      chk("abort_y", draws[36].y, 16);
    end
    send(9, 1, acc);
    wait_draws(38, 1000);
    if (draws.size() >= 38) begin
      chk("post_x", draws[37].x, 8);
      chk("post_y", draws[37].y, 2);
      chk("post_note", draws[37].note, 9);
      chk("post_latency", draws[37].start - acc, 2);
    end
    chk("ld_in_wipe", ld_in_wipe, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
